// File: rtl/fetch_bpu.sv
// Fetch front-end: PC, fetch/decode register, direct-mapped BTB with 2-bit counters.
// Define FETCH_BTB_EN to build the BTB; otherwise fetch is static not-taken.
module fetch_bpu #(
    parameter int               WIDTH     = 32,
    parameter int               BTB_DEPTH = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallF,
    input  logic             stallD,
    input  logic             flushD,
    output logic [WIDTH-1:0] pcF,
    input  logic [WIDTH-1:0] instrF,
    output logic [WIDTH-1:0] instrD,
    output logic [WIDTH-1:0] pcD,
    output logic [WIDTH-1:0] pcplus4D,
    output logic             predtakenD,
    output logic [WIDTH-1:0] predtargetD,
    input  logic             resolveD,
    input  logic             takenD,
    input  logic [WIDTH-1:0] targetD,
    output logic             mispredictD
);
    localparam int IDXB = $clog2(BTB_DEPTH);
    localparam int TAGW = WIDTH - IDXB - 2;
    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

    logic [WIDTH-1:0] pcPlus4F;
    logic [WIDTH-1:0] btbTargetF;
    logic [WIDTH-1:0] pcNext;
    logic             predF;
    logic             resD;

    assign pcPlus4F = pcF + FOUR;
    assign resD     = resolveD & ~stallD;
    assign mispredictD = resD & ((predtakenD != takenD)
                       | (takenD & (predtargetD != targetD)));

`ifdef FETCH_BTB_EN
    logic [BTB_DEPTH-1:0] btbValid;
    logic [TAGW-1:0]      btbTag    [BTB_DEPTH];
    logic [WIDTH-1:0]     btbTarget [BTB_DEPTH];
    logic [1:0]           btbCtr    [BTB_DEPTH];

    logic [IDXB-1:0] idxF;
    logic [IDXB-1:0] idxD;
    logic [TAGW-1:0] tagF;
    logic [TAGW-1:0] tagD;
    logic            hitF;
    logic            hitD;

    assign idxF = pcF[IDXB+1:2];
    assign idxD = pcD[IDXB+1:2];
    assign tagF = pcF[WIDTH-1:IDXB+2];
    assign tagD = pcD[WIDTH-1:IDXB+2];
    assign hitF = btbValid[idxF] & (btbTag[idxF] == tagF);
    assign hitD = btbValid[idxD] & (btbTag[idxD] == tagD);

    assign predF      = hitF & btbCtr[idxF][1];
    assign btbTargetF = btbTarget[idxF];

    // Valid bits and counters are reset; tag/target only matter once valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            btbValid <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btbCtr[i] <= 2'b00;
            end
        end else if (resD) begin
            if (hitD) begin
                if (takenD) begin
                    if (btbCtr[idxD] != 2'b11) begin
                        btbCtr[idxD] <= btbCtr[idxD] + 2'd1;
                    end
                end else if (btbCtr[idxD] != 2'b00) begin
                    btbCtr[idxD] <= btbCtr[idxD] - 2'd1;
                end
            end else if (takenD) begin
                btbValid[idxD] <= 1'b1;
                btbCtr[idxD]   <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && resD && takenD) begin
            btbTarget[idxD] <= targetD;
            if (!hitD) begin
                btbTag[idxD] <= tagD;
            end
        end
    end
`else
    assign predF      = 1'b0;
    assign btbTargetF = '0;
`endif

    always_comb begin
        pcNext = pcPlus4F;
        if (mispredictD) begin
            pcNext = takenD ? targetD : pcplus4D;
        end else if (stallF) begin
            pcNext = pcF;
        end else if (predF) begin
            pcNext = btbTargetF;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pcF <= RESET_PC;
        end else begin
            pcF <= pcNext;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            instrD      <= '0;
            pcD         <= '0;
            pcplus4D    <= FOUR;
            predtakenD  <= 1'b0;
            predtargetD <= '0;
        end else if (flushD | mispredictD) begin
            instrD      <= '0;
            pcD         <= pcF;
            pcplus4D    <= pcPlus4F;
            predtakenD  <= 1'b0;
            predtargetD <= '0;
        end else if (!stallD) begin
            instrD      <= instrF;
            pcD         <= pcF;
            pcplus4D    <= pcPlus4F;
            predtakenD  <= predF;
            predtargetD <= btbTargetF;
        end
    end

endmodule

// File: tb/tb_fetch_bpu.sv
// Directed bench for fetch_bpu; expectations follow FETCH_BTB_EN.
// The bench plays instruction memory and decode-stage resolver.
module tb_fetch_bpu;
    logic        clk;
    logic        reset;
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic [31:0] pcF;
    logic [31:0] instrF;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pcplus4D;
    logic        predtakenD;
    logic [31:0] predtargetD;
    logic        resolveD;
    logic        takenD;
    logic [31:0] targetD;
    logic        mispredictD;

    int nChecks = 0;
    int nErrors = 0;

    localparam logic [31:0] IMASK = 32'hA500_0000;

    fetch_bpu #(.WIDTH(32), .BTB_DEPTH(16), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD),
        .flushD(flushD), .pcF(pcF), .instrF(instrF), .instrD(instrD),
        .pcD(pcD), .pcplus4D(pcplus4D), .predtakenD(predtakenD),
        .predtargetD(predtargetD), .resolveD(resolveD), .takenD(takenD),
        .targetD(targetD), .mispredictD(mispredictD)
    );

    assign instrF = pcF ^ IMASK;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic tk, input logic [31:0] tgt);
        resolveD = 1'b1;
        takenD   = tk;
        targetD  = tgt;
        #1;
    endtask

    task automatic idle();
        resolveD = 1'b0;
        takenD   = 1'b0;
        targetD  = '0;
    endtask

    initial begin
        reset = 1'b0; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
        idle();
        tick(); tick();
        check("rst_pcF", pcF, 32'h0);
        check("rst_instrD", instrD, 32'h0);
        check("rst_pcD", pcD, 32'h0);
        check("rst_pc4D", pcplus4D, 32'h4);
        check("rst_pred", {31'b0, predtakenD}, 32'h0);
        check("rst_ptgt", predtargetD, 32'h0);

        reset = 1'b1;
        tick(); check("seq4", pcF, 32'h4);
        check("seq_instrD", instrD, 32'h0 ^ IMASK);
        tick(); check("seq8", pcF, 32'h8);
        tick(); check("seqC", pcF, 32'hC);
        tick(); tick();
        check("cold_pcD", pcD, 32'h10);
        check("cold_pred", {31'b0, predtakenD}, 32'h0);
        resolve(1'b1, 32'h40);
        check("cold_misp", {31'b0, mispredictD}, 32'h1);
        tick(); idle();
        check("cold_pcF", pcF, 32'h40);
        check("cold_flush", instrD, 32'h0);
        tick();
        resolve(1'b1, 32'h10);
        check("jmp_misp", {31'b0, mispredictD}, 32'h1);
        tick(); idle();
        check("jmp_pcF", pcF, 32'h10);

`ifdef FETCH_BTB_EN
        tick();
        check("hot_pcF", pcF, 32'h40);
        check("hot_pred", {31'b0, predtakenD}, 32'h1);
        check("hot_ptgt", predtargetD, 32'h40);
        resolve(1'b1, 32'h40);
        check("hot_ok", {31'b0, mispredictD}, 32'h0);
        resolve(1'b1, 32'h48);
        check("tgt_misp", {31'b0, mispredictD}, 32'h1);
        resolve(1'b0, 32'h0);
        check("nt_misp", {31'b0, mispredictD}, 32'h1);
        tick(); idle();
        check("nt_pcF", pcF, 32'h14);
        check("nt_flush", instrD, 32'h0);
        check("nt_pred", {31'b0, predtakenD}, 32'h0);
        tick();
        resolve(1'b1, 32'h10);
        tick(); idle();
        check("back_pcF", pcF, 32'h10);
        tick();
        check("weak_pcF", pcF, 32'h14);
        check("weak_pred", {31'b0, predtakenD}, 32'h0);
        resolve(1'b1, 32'h40);
        check("weak_misp", {31'b0, mispredictD}, 32'h1);
        tick(); idle();
        tick(); tick();
        check("t1_pred", {31'b0, predtakenD}, 32'h1);
        resolve(1'b1, 32'h40);
        check("t2_ok", {31'b0, mispredictD}, 32'h0);
        tick(); idle();
        check("loop_pcF", pcF, 32'h10);
        tick();
        resolve(1'b1, 32'h40);
        check("t3_ok", {31'b0, mispredictD}, 32'h0);
        tick(); idle();
        tick();
        resolve(1'b0, 32'h0);
        tick(); idle();
        check("dec_pcF", pcF, 32'h14);
        tick(); tick();
        check("sat_pcF", pcF, 32'h40);
        check("sat_pred", {31'b0, predtakenD}, 32'h1);

        stallF = 1'b1; stallD = 1'b1;
        resolve(1'b0, 32'h0);
        check("stall_misp", {31'b0, mispredictD}, 32'h0);
        tick();
        check("stall_pcF", pcF, 32'h40);
        check("stall_instrD", instrD, 32'h10 ^ IMASK);
        stallF = 1'b0; stallD = 1'b0; idle();
        tick(); tick();
        check("held_pcF", pcF, 32'h40);
        check("held_pred", {31'b0, predtakenD}, 32'h1);

        resolve(1'b1, 32'h50);
        check("ali_misp", {31'b0, mispredictD}, 32'h1);
        tick(); idle();
        check("ali_pcF", pcF, 32'h50);
        tick();
        check("ali_miss", pcF, 32'h54);
        check("ali_pred", {31'b0, predtakenD}, 32'h0);
        resolve(1'b1, 32'h80);
        tick(); idle();
        tick();
        check("a80_miss", pcF, 32'h84);
        resolve(1'b1, 32'h10);
        tick(); idle();
        tick();
        check("evict_pcF", pcF, 32'h14);
        check("evict_pred", {31'b0, predtakenD}, 32'h0);

        flushD = 1'b1; stallD = 1'b1;
        tick();
        flushD = 1'b0; stallD = 1'b0;
        check("fl_instrD", instrD, 32'h0);
        check("fl_pcD", pcD, 32'h14);
        check("fl_pc4D", pcplus4D, 32'h18);
        check("fl_pcF", pcF, 32'h10);

        reset = 1'b0;
        resolve(1'b1, 32'h100);
        tick(); idle();
        reset = 1'b1;
        check("rst2_pcF", pcF, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        check("rst2_pc14", pcF, 32'h14);
        tick();
        check("rst2_clear", pcF, 32'h18);
`else
        tick();
        check("nb_pcF", pcF, 32'h14);
        check("nb_pred", {31'b0, predtakenD}, 32'h0);
        resolve(1'b1, 32'h40);
        check("nb_misp", {31'b0, mispredictD}, 32'h1);
        check("nb_ptgt", predtargetD, 32'h0);
        stallF = 1'b1; stallD = 1'b1;
        #1;
        check("nb_stall_misp", {31'b0, mispredictD}, 32'h0);
        tick();
        check("nb_stall_pcF", pcF, 32'h14);
        check("nb_stall_pcD", pcD, 32'h10);
        stallF = 1'b0; stallD = 1'b0;
        #1;
        check("nb_misp2", {31'b0, mispredictD}, 32'h1);
        tick(); idle();
        check("nb_redir", pcF, 32'h40);
        check("nb_instrD", instrD, 32'h0);
        flushD = 1'b1;
        tick();
        flushD = 1'b0;
        check("nb_fl_instrD", instrD, 32'h0);
        check("nb_fl_pcD", pcD, 32'h40);
        check("nb_fl_pcF", pcF, 32'h44);
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 nChecks, nErrors);
        $finish;
    end
endmodule
